// File: rtl/alu_seq_ctrl_pkg.sv
// Shared definitions for the sequential multiply/divide controller.
package alu_seq_ctrl_pkg;

  localparam int unsigned OpWidth  = 8;
  localparam int unsigned AccWidth = 9;
  localparam int unsigned NumIter  = 8;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StFix,
    StDone
  } state_e;

endpackage

// File: rtl/alu_seq_ctrl_adder.sv
// Ripple-carry adder; the single arithmetic resource of the multiply/divide datapath.
module Parallel_Adder #(
  parameter int unsigned Width = 9
) (
  input  logic [Width-1:0] x,
  input  logic [Width-1:0] y,
  input  logic             cin,
  output logic [Width-1:0] z,
  output logic             cout,
  output logic             oflow
);

  logic [Width:0] c;

  always_comb begin
    c[0] = cin;
    z    = '0;
    for (int i = 0; i < Width; i++) begin
      z[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
  end

  assign cout  = c[Width];
  assign oflow = c[Width] ^ c[Width-1];

endmodule

// File: rtl/alu_seq_ctrl.sv
// Sequential 8-bit ALU: Booth radix-2 signed multiply and non-restoring unsigned divide
// sharing one 9-bit adder.
module alu_seq_ctrl
  import alu_seq_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  input  logic [OpWidth-1:0]  a,
  input  logic [OpWidth-1:0]  b,
  output logic                busy,
  output logic                done,
  output logic [15:0]         result,
  output logic                dbz
);

  state_e state_q, state_d;

  logic [AccWidth-1:0] acc_q;
  logic [OpWidth-1:0]  q_q;
  logic [OpWidth-1:0]  m_q;
  logic                qm1_q;
  logic                op_q;
  logic [3:0]          cnt_q;
  logic [15:0]         result_q;
  logic                dbz_q;

  logic [AccWidth-1:0] add_x, add_y, add_z;
  logic                add_cin;
  logic                unused_cout, unused_oflow;

  logic [AccWidth-1:0] m_ext, d_ext, fix_acc;
  logic                div_by_zero;

  assign m_ext       = {m_q[OpWidth-1], m_q};
  assign d_ext       = {1'b0, m_q};
  assign div_by_zero = (op == OP_DIV) && (b == '0);

  Parallel_Adder #(
    .Width(AccWidth)
  ) u_adder (
    .x    (add_x),
    .y    (add_y),
    .cin  (add_cin),
    .z    (add_z),
    .cout (unused_cout),
    .oflow(unused_oflow)
  );

  // Booth pairs 00/11 add zero, so the shift can always take the adder output.
  always_comb begin
    add_x   = acc_q;
    add_y   = '0;
    add_cin = 1'b0;
    if (state_q == StRun) begin
      if (op_q == OP_MUL) begin
        if ({q_q[0], qm1_q} == 2'b10) begin
          add_y   = ~m_ext;
          add_cin = 1'b1;
        end else if ({q_q[0], qm1_q} == 2'b01) begin
          add_y = m_ext;
        end
      end else begin
        add_x = {acc_q[AccWidth-2:0], q_q[OpWidth-1]};
        if (!acc_q[AccWidth-1]) begin
          add_y   = ~d_ext;
          add_cin = 1'b1;
        end else begin
          add_y = d_ext;
        end
      end
    end else if (state_q == StFix) begin
      add_y = d_ext;
    end
  end

  // Negative remainder after the last divide step is restored by adding D back.
  assign fix_acc = (op_q == OP_DIV && acc_q[AccWidth-1]) ? add_z : acc_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = div_by_zero ? StDone : StRun;
      end
      StRun: begin
        if (cnt_q == 4'(NumIter - 1)) state_d = StFix;
      end
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      qm1_q    <= 1'b0;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            op_q  <= op;
            m_q   <= b;
            q_q   <= a;
            qm1_q <= 1'b0;
            acc_q <= '0;
            cnt_q <= '0;
            if (div_by_zero) begin
              result_q <= {a, 8'hFF};
              dbz_q    <= 1'b1;
            end
          end
        end
        StRun: begin
          cnt_q <= cnt_q + 4'd1;
          if (op_q == OP_MUL) begin
            acc_q <= {add_z[AccWidth-1], add_z[AccWidth-1:1]};
            q_q   <= {add_z[0], q_q[OpWidth-1:1]};
            qm1_q <= q_q[0];
          end else begin
            acc_q <= add_z;
            q_q   <= {q_q[OpWidth-2:0], ~add_z[AccWidth-1]};
          end
        end
        StFix: begin
          acc_q    <= fix_acc;
          result_q <= {fix_acc[OpWidth-1:0], q_q};
          dbz_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q != StIdle);
  assign done   = (state_q == StDone);
  assign result = result_q;
  assign dbz    = dbz_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed and randomized checks of alu_seq_ctrl against hand values and a behavioural model.
module tb_alu_seq_ctrl;
  import alu_seq_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = OP_MUL;
  logic [7:0]  a = '0;
  logic [7:0]  b = '0;
  logic        busy, done, dbz;
  logic [15:0] result;

  int total = 0;
  int bad = 0;

  alu_seq_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result),
    .dbz   (dbz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // The sampling edge counts as edge 1; latency is the edge number after which done is seen.
  task automatic do_op(input string tag, input logic o, input logic [7:0] ia, input logic [7:0] ib,
                       input logic [15:0] er, input logic ed, input int lat, input int pulse_at);
    int n;
    @(negedge clk);
    check({tag, " idle"}, {14'd0, busy, done}, 16'h0000);
    rst = 1'b0;
    start = 1'b1;
    op = o;
    a = ia;
    b = ib;
    @(negedge clk);
    start = 1'b0;
    n = 1;
    while (!done && n < 20) begin
      if (n == pulse_at) begin
        start = 1'b1;
        op = OP_DIV;
        a = 8'h55;
        b = 8'h00;
      end
      @(negedge clk);
      start = 1'b0;
      n++;
    end
    check({tag, " latency"}, 16'(n), 16'(lat));
    check({tag, " busy"}, {15'd0, busy}, 16'h0001);
    check({tag, " result"}, result, er);
    check({tag, " dbz"}, {15'd0, dbz}, {15'd0, ed});
  endtask

  initial begin
    logic        o;
    logic [7:0]  ra, rb;
    logic [15:0] er;
    logic        ed;
    logic signed [15:0] prod;
    bit          seen;

    repeat (2) @(negedge clk);
    check("reset outputs", {busy, done, dbz, result[12:0]}, 16'h0000);
    check("reset result", result, 16'h0000);

    // First start is presented on the first edge after reset release.
    do_op("mul fd*07", OP_MUL, 8'hFD, 8'h07, 16'hFFEB, 1'b0, 10, 0);
    @(negedge clk);
    check("done one pulse", {15'd0, done}, 16'h0000);
    repeat (3) @(negedge clk);
    check("result held", result, 16'hFFEB);

    do_op("mul 80*80", OP_MUL, 8'h80, 8'h80, 16'h4000, 1'b0, 10, 0);
    do_op("mul 7f*81", OP_MUL, 8'h7F, 8'h81, 16'hC0FF, 1'b0, 10, 0);
    do_op("div 200/7", OP_DIV, 8'd200, 8'd7, 16'h041C, 1'b0, 10, 0);
    do_op("div 255/1", OP_DIV, 8'd255, 8'd1, 16'h00FF, 1'b0, 10, 0);
    do_op("div 13/5", OP_DIV, 8'd13, 8'd5, 16'h0302, 1'b0, 10, 0);
    do_op("div 2a/0", OP_DIV, 8'h2A, 8'h00, 16'h2AFF, 1'b1, 1, 0);
    repeat (2) @(negedge clk);
    check("dbz held", {15'd0, dbz}, 16'h0001);
    do_op("dbz cleared", OP_MUL, 8'h02, 8'h03, 16'h0006, 1'b0, 10, 0);

    // A divide-by-zero request mid-run must be ignored.
    do_op("start in run", OP_MUL, 8'hFD, 8'h07, 16'hFFEB, 1'b0, 10, 3);

    @(negedge clk);
    start = 1'b1;
    op = OP_MUL;
    a = 8'h10;
    b = 8'h10;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("busy before rst", {15'd0, busy}, 16'h0001);
    rst = 1'b1;
    #1;
    check("rst busy/done/dbz", {13'd0, busy, done, dbz}, 16'h0000);
    check("rst result", result, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check("no done after rst", {15'd0, seen}, 16'h0000);

    rst = 1'b1;
    do_op("start after rst", OP_MUL, 8'h80, 8'h80, 16'h4000, 1'b0, 10, 0);

    // Each call presents start in the IDLE cycle right after DONE.
    for (int i = 0; i < 1000; i++) begin
      o  = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = 8'($urandom);
      if ($urandom_range(0, 15) == 0) rb = 8'h00;
      if (o == OP_MUL) begin
        prod = $signed(ra) * $signed(rb);
        er = prod;
        ed = 1'b0;
      end else if (rb == 8'h00) begin
        er = {ra, 8'hFF};
        ed = 1'b1;
      end else begin
        er = {ra % rb, ra / rb};
        ed = 1'b0;
      end
      do_op("random", o, ra, rb, er, ed, (o == OP_DIV && rb == 8'h00) ? 1 : 10, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
